scc_mouse_quad_ctrl: RTL

//  Converts signed relative mouse motion packets into paced quadrature steps on the X1/X2 and Y1/Y2 lines.
//  X1/Y1 drive the SCC dcd_a/dcd_b inputs, where each edge latches an ext/status interrupt. X2/Y2 drive VIA port B for direction.

---
 rtl/scc_mouse_pkg.sv | 19 +
 rtl/scc_mouse_quad_ctrl_axis.sv | 50 +++++
 rtl/scc_mouse_quad_ctrl.sv | 96 +++++++++
 3 files changed

// File: rtl/scc_mouse_pkg.sv
// scc_mouse_pkg: shared types, constants and saturating add for the SCC mouse quadrature controller.
//   state_e      FSM states IDLE/SETUP/EDGE/HOLD
//   axis_e       stepped axis selector AX_X/AX_Y
//   ACCEL_THRESH magnitude above which the accelerated HOLD is used (MOUSE_ACCEL_EN builds)
//   sat_add      a+b clamped to the signed range of an acc_w-bit value
package scc_mouse_pkg;
   typedef enum logic [1:0] {IDLE, SETUP, EDGE, HOLD} state_e;
   typedef enum logic {AX_X, AX_Y} axis_e;
   localparam int ACCEL_THRESH = 32;
   function automatic logic signed [31:0] sat_add(input logic signed [31:0] a, input logic signed [31:0] b, input int acc_w);
      logic signed [31:0] s;
      logic signed [31:0] hi;
      logic signed [31:0] lo;
      s  = a + b;
      hi = (32'sd1 <<< (acc_w - 1)) - 32'sd1;
      lo = -hi - 32'sd1;
      return (s > hi) ? hi : (s < lo) ? lo : s;
   endfunction
endpackage

// File: rtl/scc_mouse_quad_ctrl_axis.sv
// scc_mouse_axis: one axis of the mouse -- saturating motion accumulator plus its quadrature line pair.
//   clk, reset_n, cep       clock, async active-low reset, clock enable
//   add_i, delta_i          accept strobe and signed 9-bit motion delta
//   set_dir_i, do_edge_i    SETUP/EDGE strobes from the controller for this axis
//   dir_i                   latched step direction (1 = negative)
//   line1_o, line2_o        edge line (to SCC DCD) and direction line (to VIA)
//   nonzero_o, neg_o, mag_o accumulator status for arbitration and acceleration
module scc_mouse_axis
   import scc_mouse_pkg::*;
#(
   parameter int ACC_W = 10
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               cep,
   input  logic               add_i,
   input  logic signed [8:0]  delta_i,
   input  logic               set_dir_i,
   input  logic               do_edge_i,
   input  logic               dir_i,
   output logic               line1_o,
   output logic               line2_o,
   output logic               nonzero_o,
   output logic               neg_o,
   output logic [ACC_W-1:0]   mag_o
);
   logic signed [ACC_W-1:0] acc_q, acc_d;
   logic signed [31:0] adj;
   logic line1_q, line2_q;
   // A packet and a step in the same cycle are folded into one saturating update.
   assign adj   = (add_i ? 32'(delta_i) : 32'sd0) - (do_edge_i ? (dir_i ? -32'sd1 : 32'sd1) : 32'sd0);
   assign acc_d = ACC_W'(sat_add(32'(acc_q), adj, ACC_W));
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         acc_q   <= '0;
         line1_q <= 1'b0;
         line2_q <= 1'b0;
      end else if (cep) begin
         acc_q <= acc_d;
         // line2 is set so that it equals the post-toggle line1 for a positive step.
         if (set_dir_i) line2_q <= dir_i ? line1_q : ~line1_q;
         if (do_edge_i) line1_q <= ~line1_q;
      end
   end
   assign line1_o   = line1_q;
   assign line2_o   = line2_q;
   assign nonzero_o = |acc_q;
   assign neg_o     = acc_q[ACC_W-1];
   assign mag_o     = acc_q[ACC_W-1] ? ACC_W'(-acc_q) : ACC_W'(acc_q);
endmodule

// File: rtl/scc_mouse_quad_ctrl.sv
// scc_mouse_quad_ctrl: paces signed mouse motion packets into quadrature steps on X1/X2 and Y1/Y2.
//   clk, reset_n, cep     clock, async active-low reset, clock enable
//   move_valid/ready      motion packet handshake (ready is always 1; overflow saturates)
//   move_dx, move_dy      signed 9-bit deltas
//   x1, y1                edge lines to SCC dcd_a/dcd_b
//   x2, y2                direction lines to VIA PB4/PB5
//   busy                  stepping in progress or motion pending
// One shared step timer, round-robin between axes, so at most one DCD edge per step period.
// Optional MOUSE_ACCEL_EN: shortens HOLD to STEP_DIV/4 ticks while the stepped axis has |acc| > ACCEL_THRESH.
module scc_mouse_quad_ctrl
   import scc_mouse_pkg::*;
#(
   parameter int STEP_DIV = 4096,
   parameter int ACC_W    = 10
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       cep,
   input  logic       move_valid,
   output logic       move_ready,
   input  logic [8:0] move_dx,
   input  logic [8:0] move_dy,
   output logic       x1,
   output logic       x2,
   output logic       y1,
   output logic       y2,
   output logic       busy
);
   localparam int TW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
   state_e state_q;
   axis_e axis_q, rr_q, pick;
   logic dir_q;
   logic [TW-1:0] timer_q, timer_nx;
   logic x_nz, y_nz, x_neg, y_neg, hold_done;
   logic [ACC_W-1:0] x_mag, y_mag;
   scc_mouse_axis #(.ACC_W(ACC_W)) u_x (
      .clk(clk), .reset_n(reset_n), .cep(cep),
      .add_i(move_valid), .delta_i(move_dx),
      .set_dir_i(state_q == SETUP && axis_q == AX_X),
      .do_edge_i(state_q == EDGE && axis_q == AX_X),
      .dir_i(dir_q),
      .line1_o(x1), .line2_o(x2),
      .nonzero_o(x_nz), .neg_o(x_neg), .mag_o(x_mag)
   );
   scc_mouse_axis #(.ACC_W(ACC_W)) u_y (
      .clk(clk), .reset_n(reset_n), .cep(cep),
      .add_i(move_valid), .delta_i(move_dy),
      .set_dir_i(state_q == SETUP && axis_q == AX_Y),
      .do_edge_i(state_q == EDGE && axis_q == AX_Y),
      .dir_i(dir_q),
      .line1_o(y1), .line2_o(y2),
      .nonzero_o(y_nz), .neg_o(y_neg), .mag_o(y_mag)
   );
   assign move_ready = 1'b1;
   assign busy       = (state_q != IDLE) || x_nz || y_nz;
   assign pick       = (x_nz && y_nz) ? rr_q : (x_nz ? AX_X : AX_Y);
   assign timer_nx   = timer_q + TW'(1);
`ifdef MOUSE_ACCEL_EN
   logic fast;
   assign fast      = 32'((axis_q == AX_X) ? x_mag : y_mag) > 32'(ACCEL_THRESH);
   assign hold_done = timer_nx == (fast ? TW'(STEP_DIV / 4 - 1) : TW'(STEP_DIV - 1));
`else
   // Magnitudes only feed the acceleration compare, absent in this build.
   logic unused_mag;
   assign unused_mag = ^{x_mag, y_mag};
   assign hold_done  = timer_nx == TW'(STEP_DIV - 1);
`endif
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         axis_q  <= AX_X;
         rr_q    <= AX_X;
         dir_q   <= 1'b0;
         timer_q <= '0;
      end else if (cep) begin
         case (state_q)
            IDLE: if (x_nz || y_nz) begin
               axis_q  <= pick;
               dir_q   <= (pick == AX_X) ? x_neg : y_neg;
               state_q <= SETUP;
            end
            SETUP: state_q <= EDGE;
            EDGE: begin
               rr_q    <= (axis_q == AX_X) ? AX_Y : AX_X;
               timer_q <= '0;
               state_q <= HOLD;
            end
            HOLD: begin
               timer_q <= timer_nx;
               if (hold_done) state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end
endmodule
